// File: rtl/sort_core_arbiter.sv
// sort_core_arbiter: shares one ap_ctrl_hs insertionSort core between two
// requesters. Round-robin grant, one call in flight, watchdog abort, and a
// count of completed calls.
module sort_core_arbiter #(
  parameter int DATA_W  = 16,
  parameter int POS_W   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [POS_W-1:0]  req0_pos,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [POS_W-1:0]  req1_pos,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  // core side
  output logic              core_start,
  input  logic              core_ready,
  input  logic              core_done,
  input  logic              core_idle,
  output logic [DATA_W-1:0] core_din,
  output logic [POS_W-1:0]  core_pos,
  input  logic [DATA_W-1:0] core_return,
  // status
  output logic              busy,
  output logic              timeout_flag,
  output logic [15:0]       call_count
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                core_start_q, core_start_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [15:0]         wd_q, wd_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rerr_q, rerr_d;
  logic                tflag_q, tflag_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          rst_sync_q;
  logic                rst_n_int;

  logic                win;
  logic                accept;
  logic                wd_hit;
  logic                rsp_hs;

  // Reset asserts asynchronously and releases two clocks after ap_rst_n rises.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    win    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept = (state_q == IDLE) && core_idle && (req0_valid || req1_valid) && rst_n_int;
  end

  assign req0_ready   = accept && !win;
  assign req1_ready   = accept &&  win;
  assign rsp0_valid   = (state_q == RESP) && !last_grant_q;
  assign rsp1_valid   = (state_q == RESP) &&  last_grant_q;
  assign rsp_data     = rdata_q;
  assign rsp_err      = rerr_q;
  assign core_start   = core_start_q;
  assign core_din     = din_q;
  assign core_pos     = pos_q;
  assign busy         = (state_q != IDLE);
  assign timeout_flag = tflag_q;
  assign call_count   = cnt_q;

  assign wd_hit = (wd_q == 16'(TIMEOUT));
  assign rsp_hs = last_grant_q ? rsp1_ready : rsp0_ready;

  // Call sequencing: accept, start handshake, wait for done or watchdog, return.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    core_start_d = core_start_q;
    din_d        = din_q;
    pos_d        = pos_q;
    wd_d         = wd_q;
    rdata_d      = rdata_q;
    rerr_d       = rerr_q;
    tflag_d      = tflag_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          din_d        = win ? req1_data : req0_data;
          pos_d        = win ? req1_pos  : req0_pos;
          last_grant_d = win;
          wd_d         = '0;
          core_start_d = 1'b1;
          state_d      = START;
        end
      end
      START, WAIT: begin
        // done has priority over the watchdog; in START, ap_done implies ap_ready
        if (core_done) begin
          rdata_d      = core_return;
          rerr_d       = 1'b0;
          cnt_d        = cnt_q + 16'd1;
          core_start_d = 1'b0;
          state_d      = RESP;
        end else if (wd_hit) begin
          rdata_d      = '0;
          rerr_d       = 1'b1;
          tflag_d      = 1'b1;
          core_start_d = 1'b0;
          state_d      = RESP;
        end else begin
          wd_d = wd_q + 16'd1;
          if (state_q == START && core_ready) begin
            core_start_d = 1'b0;
            state_d      = WAIT;
          end
        end
      end
      RESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      core_start_q <= 1'b0;
      din_q        <= '0;
      pos_q        <= '0;
      wd_q         <= '0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
      tflag_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      core_start_q <= core_start_d;
      din_q        <= din_d;
      pos_q        <= pos_d;
      wd_q         <= wd_d;
      rdata_q      <= rdata_d;
      rerr_q       <= rerr_d;
      tflag_q      <= tflag_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sort_core_arbiter.sv
// Bench for sort_core_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_sort_core_arbiter;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int TO = 15;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic [PW-1:0] req0_pos = '0, req1_pos = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic rsp_err, core_start, busy, timeout_flag;
  logic core_ready = 1'b0, core_done = 1'b0, core_idle = 1'b1;
  logic [DW-1:0] core_din, core_return = '0;
  logic [PW-1:0] core_pos;
  logic [15:0] call_count;

  sort_core_arbiter #(.DATA_W(DW), .POS_W(PW), .TIMEOUT(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_pos(req0_pos),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_pos(req1_pos),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .core_start(core_start), .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .core_din(core_din), .core_pos(core_pos), .core_return(core_return),
    .busy(busy), .timeout_flag(timeout_flag), .call_count(call_count)
  );

  always #5 ap_clk = ~ap_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  // request modes: 0 off, 1 continuous, 2 random, 3 one-shot (os_* payload)
  int mode0 = 0, mode1 = 0, rmode0 = 0, rmode1 = 0;
  int id0 = 0, id1 = 0, srv0 = 0, srv1 = 0;
  logic [DW-1:0] os_d0 = '0, os_d1 = '0;
  logic [PW-1:0] os_p0 = '0, os_p1 = '0;
  bit acc0_s = 1'b0, acc1_s = 1'b0;
  // core knobs
  bit c_rnd = 1'b0;
  int c_rl = 0, c_dl = 4;
  logic [DW-1:0] c_ret = '0;

  always @(negedge ap_clk) begin
    acc0_s = req0_valid && req0_ready;
    acc1_s = req1_valid && req1_ready;
  end

  task automatic drv(input int mode, input bit acc, input int id, inout int srv,
                     inout logic v, inout logic [DW-1:0] d, inout logic [PW-1:0] p,
                     input logic [DW-1:0] od, input logic [PW-1:0] op);
    case (mode)
      0: v = 1'b0;
      1, 2: if (!v || acc) begin
        v = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        d = DW'($urandom);
        p = PW'($urandom);
      end
      default: begin
        if (acc) srv = id;
        if (srv != id) begin
          if (!v) begin v = 1'b1; d = od; p = op; end
        end else v = 1'b0;
      end
    endcase
  endtask

  // Requester and response-side drivers, updated just after each rising edge.
  always @(posedge ap_clk) begin
    #1;
    drv(mode0, acc0_s, id0, srv0, req0_valid, req0_data, req0_pos, os_d0, os_p0);
    drv(mode1, acc1_s, id1, srv1, req1_valid, req1_data, req1_pos, os_d1, os_p1);
    rsp0_ready = (rmode0 == 0) ? 1'b1 : (rmode0 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    rsp1_ready = (rmode1 == 0) ? 1'b1 : (rmode1 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Core model: k counts cycles from the first core_start cycle (k=0).
  bit running = 1'b0;
  int k = 0, rl = 0, dl = 0;
  logic [DW-1:0] ret = '0;
  always @(posedge ap_clk) begin
    #1;
    if (running) begin
      if (core_done) running = 1'b0;
      else k++;
    end else if (core_start) begin
      running = 1'b1;
      k = 0;
      if (c_rnd) begin
        rl = $urandom_range(0, 2);
        case ($urandom_range(0, 9))
          0:       dl = TO + 3;              // hangs past the watchdog
          1:       dl = TO;                  // done exactly at the limit
          default: dl = rl + $urandom_range(0, 8);
        endcase
        ret = DW'($urandom);
      end else begin
        rl = c_rl; dl = c_dl; ret = c_ret;
      end
    end
    core_ready  = running && (k == rl);
    core_done   = running && (k == dl);
    core_return = (running && k == dl) ? ret : 16'hBEEF;
    core_idle   = !running;
  end

  // ---------------- reference model ----------------
  // phase 0 idle, 1 call in flight, 2 response pending
  int m_sync = 0, m_phase = 0, m_el = 0;
  bit m_last = 1'b1, m_owner = 1'b0, m_acked = 1'b0, m_rerr = 1'b0, m_tflag = 1'b0;
  logic [DW-1:0] m_data = '0, m_rdata = '0;
  logic [PW-1:0] m_pos = '0;
  logic [15:0] m_cnt = '0;

  always @(negedge ap_clk) begin
    bit act, win, acc;
    if (!ap_rst_n) begin
      m_sync = 0; m_phase = 0; m_el = 0; m_last = 1'b1; m_owner = 1'b0; m_acked = 1'b0;
      m_rerr = 1'b0; m_tflag = 1'b0; m_data = '0; m_rdata = '0; m_pos = '0; m_cnt = '0;
    end else begin
      act = (m_sync >= 2);
      win = (req0_valid && req1_valid) ? !m_last : req1_valid;
      acc = act && m_phase == 0 && core_idle && (req0_valid || req1_valid);
      check("req0_ready", 32'(req0_ready), 32'(acc && !win));
      check("req1_ready", 32'(req1_ready), 32'(acc && win));
      check("core_start", 32'(core_start), 32'(m_phase == 1 && !m_acked));
      check("core_din", 32'(core_din), 32'(m_data));
      check("core_pos", 32'(core_pos), 32'(m_pos));
      check("rsp0_valid", 32'(rsp0_valid), 32'(m_phase == 2 && !m_owner));
      check("rsp1_valid", 32'(rsp1_valid), 32'(m_phase == 2 && m_owner));
      check("rsp_data", 32'(rsp_data), 32'(m_rdata));
      check("rsp_err", 32'(rsp_err), 32'(m_rerr));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
      check("call_count", 32'(call_count), 32'(m_cnt));
      if (act) begin
        case (m_phase)
          0: if (acc) begin
            m_owner = win; m_last = win;
            m_data = win ? req1_data : req0_data;
            m_pos  = win ? req1_pos : req0_pos;
            m_el = 0; m_acked = 1'b0; m_phase = 1;
          end
          1: begin
            if (core_done) begin
              m_rdata = core_return; m_rerr = 1'b0; m_cnt = m_cnt + 16'd1; m_phase = 2;
            end else if (m_el == TO) begin
              m_rdata = '0; m_rerr = 1'b1; m_tflag = 1'b1; m_phase = 2;
            end else begin
              if (core_ready) m_acked = 1'b1;
              m_el++;
            end
          end
          default: if (m_owner ? rsp1_ready : rsp0_ready) m_phase = 0;
        endcase
      end
      if (m_sync < 2) m_sync++;
    end
  end

  // ---------------- directed + random sequence ----------------
  task automatic do_reset();
    @(posedge ap_clk); #2 ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
  endtask

  task automatic wait_quiet(input string nm);
    int n = 0;
    do begin @(negedge ap_clk); n++; end while ((busy || !core_idle) && n < 200);
    check(nm, 32'(busy || !core_idle), 32'(0));
  endtask

  initial begin
    int n, a, sr, sc, wc, g, stray, bad_v, bad_d, bad_r;
    int gl[4];
    logic [DW-1:0] din_seen;

    repeat (3) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    check("reset_count", 32'(call_count), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));

    // T1: single call from requester 0
    c_rl = 0; c_dl = 4; c_ret = 16'h0042;
    os_d0 = 16'h1234; os_p0 = 8'd3; mode0 = 3; id0++;
    n = 0; din_seen = '0;
    do begin
      @(negedge ap_clk); n++;
      if (busy && !rsp0_valid) din_seen = core_din;
    end while (!rsp0_valid && n < 50);
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'(1));
    check("t1_rsp_data", 32'(rsp_data), 32'h0042);
    check("t1_rsp_err", 32'(rsp_err), 32'(0));
    check("t1_call_count", 32'(call_count), 32'(1));
    check("t1_core_din", 32'(din_seen), 32'h1234);
    check("t1_core_pos", 32'(core_pos), 32'(3));
    mode0 = 0;
    wait_quiet("t1_quiet");

    // T2: contention after reset, grant order 0,1,0,1
    do_reset();
    c_dl = 2; mode0 = 1; mode1 = 1;
    g = 0; n = 0;
    do begin
      @(negedge ap_clk); n++;
      if (req0_valid && req0_ready) begin gl[g] = 0; g++; end
      else if (req1_valid && req1_ready) begin gl[g] = 1; g++; end
    end while (g < 4 && n < 300);
    mode0 = 0; mode1 = 0;
    check("t2_grants", 32'(g), 32'(4));
    for (int i = 0; i < 4; i++) check("t2_order", 32'(gl[i]), 32'(i % 2));
    wait_quiet("t2_quiet");

    // T3: ready+done on the first start cycle
    do_reset();
    c_rl = 0; c_dl = 0; c_ret = 16'h00C3; mode0 = 3; id0++;
    n = 0; a = -100; sc = 0; wc = 0;
    do begin
      @(negedge ap_clk); n++;
      if (req0_valid && req0_ready) a = n;
      if (core_start) sc++;
      if (busy && !core_start && !rsp0_valid && !rsp1_valid) wc++;
    end while (!rsp0_valid && n < 50);
    check("t3_latency", 32'(n - a), 32'(2));
    check("t3_start_cycles", 32'(sc), 32'(1));
    check("t3_wait_cycles", 32'(wc), 32'(0));
    check("t3_rsp_data", 32'(rsp_data), 32'h00C3);
    mode0 = 0;
    wait_quiet("t3_quiet");

    // T4: hung core, abort, late stray done while response is held
    c_rl = 0; c_dl = TO + 3; rmode1 = 2; os_d1 = 16'hAAAA; os_p1 = 8'd9; mode1 = 3; id1++;
    n = 0; sr = -100;
    do begin
      @(negedge ap_clk); n++;
      if (core_start && sr < 0) sr = n;
    end while (!rsp1_valid && n < 100);
    check("t4_abort_delay", 32'(n - sr), 32'(TO + 1));
    check("t4_rsp_err", 32'(rsp_err), 32'(1));
    check("t4_rsp_data", 32'(rsp_data), 32'(0));
    check("t4_timeout_flag", 32'(timeout_flag), 32'(1));
    check("t4_call_count", 32'(call_count), 32'(1));
    stray = 0;
    repeat (6) begin @(negedge ap_clk); if (core_done) stray++; end
    check("t4_stray_seen", 32'(stray), 32'(1));
    check("t4_rsp_held", 32'(rsp1_valid), 32'(1));
    check("t4_rsp_data_after_stray", 32'(rsp_data), 32'(0));
    check("t4_count_after_stray", 32'(call_count), 32'(1));
    rmode1 = 0; mode1 = 0;
    wait_quiet("t4_quiet");

    // T4b: done exactly at the watchdog limit completes normally
    c_dl = TO; c_ret = 16'h5A5A; os_d0 = 16'h0101; mode0 = 3; id0++;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!rsp0_valid && n < 100);
    check("t4b_rsp_err", 32'(rsp_err), 32'(0));
    check("t4b_rsp_data", 32'(rsp_data), 32'h5A5A);
    check("t4b_call_count", 32'(call_count), 32'(2));
    check("t4b_flag_sticky", 32'(timeout_flag), 32'(1));
    mode0 = 0;
    wait_quiet("t4b_quiet");

    // T5: response backpressure on requester 1
    c_dl = 3; c_ret = 16'h7777; rmode1 = 2; os_d1 = 16'h3333; mode1 = 3; id1++;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!rsp1_valid && n < 100);
    mode0 = 1;
    bad_v = 0; bad_d = 0; bad_r = 0;
    repeat (10) begin
      @(negedge ap_clk);
      if (!rsp1_valid) bad_v++;
      if (rsp_data !== 16'h7777) bad_d++;
      if (req0_ready) bad_r++;
    end
    check("t5_rsp1_valid_held", 32'(bad_v), 32'(0));
    check("t5_rsp_data_held", 32'(bad_d), 32'(0));
    check("t5_req0_blocked", 32'(bad_r), 32'(0));
    rmode1 = 0;
    @(negedge ap_clk);
    check("t5_handshake", 32'(rsp1_valid && rsp1_ready), 32'(1));
    @(negedge ap_clk);
    check("t5_idle_after", 32'(busy), 32'(0));
    check("t5_req0_accept", 32'(req0_ready), 32'(1));
    mode0 = 0; mode1 = 0;
    wait_quiet("t5_quiet");

    // T6: async reset in the middle of WAIT
    c_rl = 0; c_dl = 30; mode0 = 3; id0++;
    n = 0; wc = 0;
    do begin
      @(negedge ap_clk); n++;
      if (busy && !core_start && !rsp0_valid) wc++;
    end while (wc < 3 && n < 100);
    mode0 = 1;
    @(posedge ap_clk); #3 ap_rst_n = 1'b0;
    #1;
    check("t6_busy", 32'(busy), 32'(0));
    check("t6_core_start", 32'(core_start), 32'(0));
    check("t6_req0_ready", 32'(req0_ready), 32'(0));
    check("t6_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'(0));
    check("t6_rsp_data", 32'(rsp_data), 32'(0));
    check("t6_rsp_err", 32'(rsp_err), 32'(0));
    check("t6_core_din", 32'(core_din), 32'(0));
    check("t6_core_pos", 32'(core_pos), 32'(0));
    check("t6_timeout_flag", 32'(timeout_flag), 32'(0));
    check("t6_call_count", 32'(call_count), 32'(0));
    mode0 = 0;
    repeat (2) @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    wait_quiet("t6_stray_done");
    c_dl = 2; c_ret = 16'h0F0F; mode0 = 3; id0++;
    n = 0;
    do begin @(negedge ap_clk); n++; end while (!rsp0_valid && n < 100);
    check("t6_post_rsp", 32'(rsp_data), 32'h0F0F);
    check("t6_post_count", 32'(call_count), 32'(1));
    mode0 = 0;
    wait_quiet("t6_quiet");

    // Randomized traffic with random core timing and response backpressure
    c_rnd = 1'b1; mode0 = 2; mode1 = 2; rmode0 = 1; rmode1 = 1;
    repeat (4000) @(negedge ap_clk);
    mode0 = 0; mode1 = 0; rmode0 = 0; rmode1 = 0;
    wait_quiet("rand_quiet");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
